// File: rtl/des_rounds_param.sv
// des_rounds_param
// Iterative DES core with a configurable round count and a configurable number
// of Feistel rounds evaluated per clock.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst        - asynchronous active-high reset
//   start      - request pulse, sampled on the rising edge while not running
//   decrypt    - 0 = encrypt, 1 = decrypt, sampled together with start
//   message    - 64-bit input block, DES bit numbering (bit 1 is the MSB)
//   round_keys - ROUNDS subkeys of 48 bits, K1 in bits 1..48
//   busy       - high while rounds are being computed
//   done       - one-cycle pulse in the cycle after the final round
//   result     - registered output block, held until the next completion
module des_rounds_param #(
   parameter int ROUNDS = 16,
   parameter int UNROLL = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 decrypt,
   input  logic [1:64]          message,
   input  logic [1:48*ROUNDS]   round_keys,
   output logic                 busy,
   output logic                 done,
   output logic [1:64]          result
);

   localparam int CW = $clog2(ROUNDS + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Eight S-boxes, 4 rows of 16 nibbles each, S1 row 0 entry 0 in the top nibble.
   localparam logic [2047:0] SBOX = {
      256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
      256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
      256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
      256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
      256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
      256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
      256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
      256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
   };

   localparam int P_TAB [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   // The initial permutation follows a regular pattern: output row r takes
   // the even source columns (58,60,62,64) first, then the odd ones, stepping
   // down by 8 along each row.
   function automatic int ip_src(input int pos);
      int r;
      int c;
      r = (pos - 1) / 8;
      c = (pos - 1) % 8;
      if (r < 4) return 58 + 2 * r - 8 * c;
      else       return 57 + 2 * (r - 4) - 8 * c;
   endfunction

   function automatic logic [1:64] initial_perm(input logic [1:64] x);
      logic [1:64] y;
      y = '0;
      for (int p = 1; p <= 64; p++) y[p] = x[ip_src(p)];
      return y;
   endfunction

   // The final permutation is the exact inverse of the initial one.
   function automatic logic [1:64] final_perm(input logic [1:64] x);
      logic [1:64] y;
      y = '0;
      for (int p = 1; p <= 64; p++) y[ip_src(p)] = x[p];
      return y;
   endfunction

   // Expansion: each 6-bit group j covers R bits 4j..4j+5, wrapping 0->32, 33->1.
   function automatic logic [1:48] expand(input logic [1:32] r);
      logic [1:48] y;
      y = '0;
      for (int j = 0; j < 8; j++)
         for (int k = 0; k < 6; k++)
            y[6 * j + k + 1] = r[((4 * j + k + 31) % 32) + 1];
      return y;
   endfunction

   function automatic logic [1:32] feistel(input logic [1:32] r, input logic [1:48] k);
      logic [1:48] x;
      logic [1:32] s_out;
      logic [1:32] y;
      logic [5:0]  six;
      int          idx;
      x     = expand(r) ^ k;
      s_out = '0;
      y     = '0;
      for (int s = 0; s < 8; s++) begin
         six = x[6 * s + 1 +: 6];
         idx = s * 64 + (2 * int'(six[5]) + int'(six[0])) * 16 + int'(six[4:1]);
         s_out[4 * s + 1 +: 4] = SBOX[2047 - 4 * idx -: 4];
      end
      for (int i = 1; i <= 32; i++) y[i] = s_out[P_TAB[i - 1]];
      return y;
   endfunction

   state_t                state;
   state_t                state_next;
   logic [1:32]           l_reg;
   logic [1:32]           r_reg;
   logic [1:48*ROUNDS]    key_reg;
   logic [1:48*ROUNDS]    key_load;
   logic [CW-1:0]         cnt;
   logic [1:32]           l_next;
   logic [1:32]           r_next;
   logic                  last_step;
   logic                  accept;

   // Decryption is the same datapath with the subkeys in reverse order, so the
   // mode is absorbed into the key register when the request is accepted and
   // the round logic always walks the keys from the front.
   always_comb begin
      key_load = round_keys;
      if (decrypt) begin
         for (int i = 0; i < ROUNDS; i++)
            key_load[48 * i + 1 +: 48] = round_keys[48 * (ROUNDS - 1 - i) + 1 +: 48];
      end
   end

   // UNROLL consecutive rounds starting at the current counter value. The key
   // index is clamped so the select stays in range outside RUN, where the
   // outputs of this block are not used.
   always_comb begin
      l_next = l_reg;
      r_next = r_reg;
      for (int u = 0; u < UNROLL; u++) begin : round_step
         int          kidx;
         logic [1:48] rk;
         logic [1:32] old_r;
         kidx = int'(cnt) + u;
         if (kidx >= ROUNDS) kidx = 0;
         rk     = key_reg[48 * kidx + 1 +: 48];
         old_r  = r_next;
         r_next = l_next ^ feistel(r_next, rk);
         l_next = old_r;
      end
   end

   assign last_step = (int'(cnt) + UNROLL >= ROUNDS);
   assign accept    = (state != RUN) && start;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state and status outputs; both outputs decode the state register
   // only, so nothing on the inputs reaches them combinationally.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_step) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_next = RUN;
            else       state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: load on an accepted request, iterate in RUN, and capture the
   // output block on the final step with the last swap undone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_reg   <= '0;
         r_reg   <= '0;
         key_reg <= '0;
         cnt     <= '0;
         result  <= '0;
      end else if (accept) begin
         {l_reg, r_reg} <= initial_perm(message);
         key_reg        <= key_load;
         cnt            <= '0;
      end else if (state == RUN) begin
         l_reg <= l_next;
         r_reg <= r_next;
         cnt   <= cnt + CW'(UNROLL);
         if (last_step) result <= final_perm({r_next, l_next});
      end
   end

endmodule

// File: tb/tb_des_rounds_param.sv
// tb_des_rounds_param
// Drives four instances of des_rounds_param (16/1, 16/4, 16/16 and 4/1 rounds
// per clock) and checks them against a DES model written directly from the
// standard tables. Instance A is also tracked cycle by cycle by a transaction
// model covering busy, done and result.
module tb_des_rounds_param;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  start_v = '0;
   logic        dec = 1'b0;
   logic [1:64] msg = '0;
   logic [1:768] keys16 = '0;
   logic [1:192] keys4 = '0;
   logic [3:0]  busy_v;
   logic [3:0]  done_v;
   logic [1:64] res_a, res_b, res_c, res_d;

   int total = 0;
   int bad = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   localparam logic [1:768] KSCHED = {
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };
   localparam logic [63:0] PLAIN  = 64'h0123456789ABCDEF;
   localparam logic [63:0] CIPHER = 64'h85E813540F0AB405;

   des_rounds_param #(.ROUNDS(16), .UNROLL(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .decrypt(dec), .message(msg),
      .round_keys(keys16), .busy(busy_v[0]), .done(done_v[0]), .result(res_a));
   des_rounds_param #(.ROUNDS(16), .UNROLL(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .decrypt(dec), .message(msg),
      .round_keys(keys16), .busy(busy_v[1]), .done(done_v[1]), .result(res_b));
   des_rounds_param #(.ROUNDS(16), .UNROLL(16)) dut_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .decrypt(dec), .message(msg),
      .round_keys(keys16), .busy(busy_v[2]), .done(done_v[2]), .result(res_c));
   des_rounds_param #(.ROUNDS(4), .UNROLL(1)) dut_d (
      .clk(clk), .rst(rst), .start(start_v[3]), .decrypt(dec), .message(msg),
      .round_keys(keys4), .busy(busy_v[3]), .done(done_v[3]), .result(res_d));

   // Standard DES tables, entries are 1-based DES bit numbers.
   int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                     62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                     38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                     36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                     34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                     16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   logic [63:0] S_ROWS [32] = '{
      64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
      64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
      64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
      64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
      64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
      64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
      64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
      64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

   // Whole-block DES with `rounds` rounds; keys packed K1 first at the top.
   function automatic logic [63:0] desModel(input logic [63:0] blk, input logic [767:0] ks,
                                            input bit dec_mode, input int rounds);
      logic [63:0] lr, pre, out;
      logic [31:0] lh, rh, f, s_out, nr;
      logic [47:0] e, k, x;
      logic [5:0]  six;
      int kidx, row, col;
      for (int b = 1; b <= 64; b++) lr[64 - b] = blk[64 - IP_T[b - 1]];
      lh = lr[63:32];
      rh = lr[31:0];
      for (int j = 1; j <= rounds; j++) begin
         kidx = dec_mode ? rounds + 1 - j : j;
         k = ks[767 - 48 * (kidx - 1) -: 48];
         for (int b = 1; b <= 48; b++) e[48 - b] = rh[32 - E_T[b - 1]];
         x = e ^ k;
         for (int s = 0; s < 8; s++) begin
            six = x[47 - 6 * s -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s_out[31 - 4 * s -: 4] = S_ROWS[4 * s + row][63 - 4 * col -: 4];
         end
         for (int b = 1; b <= 32; b++) f[32 - b] = s_out[32 - P_T[b - 1]];
         nr = lh ^ f;
         lh = rh;
         rh = nr;
      end
      pre = {rh, lh};
      for (int b = 1; b <= 64; b++) out[64 - b] = pre[64 - FP_T[b - 1]];
      return out;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Transaction model for instance A: a request accepted while idle finishes
   // 16 edges later; requests seen while an operation is pending are dropped.
   int          m_remain = 0;
   bit          m_done = 1'b0;
   logic [63:0] m_result = '0;
   logic [63:0] m_pending = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_remain = 0;
         m_done   = 1'b0;
         m_result = '0;
      end else begin
         m_done = 1'b0;
         if (m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) begin
               m_result = m_pending;
               m_done   = 1'b1;
            end
         end else if (start_v[0]) begin
            m_pending = desModel(msg, keys16, dec, 16);
            m_remain  = 16;
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("A.busy", {63'b0, busy_v[0]}, {63'b0, (m_remain > 0)});
         checkOutput("A.done", {63'b0, done_v[0]}, {63'b0, m_done});
         checkOutput("A.result", res_a, m_result);
      end
   end

   task automatic applyStimulus(input int which, input logic [63:0] m, input logic [767:0] k,
                                input bit d);
      @(negedge clk);
      msg    = m;
      keys16 = k;
      dec    = d;
      start_v[which] = 1'b1;
      @(negedge clk);
      start_v[which] = 1'b0;
   endtask

   // Called at the first negedge after the accepting edge; edges counts
   // further rising edges until done is seen.
   task automatic waitDone(input int which, output int edges, output int busy_cnt);
      edges = 0;
      busy_cnt = 0;
      while (!done_v[which] && edges < 40) begin
         if (busy_v[which]) busy_cnt++;
         @(negedge clk);
         edges++;
      end
      if (!done_v[which]) begin
         total++;
         bad++;
         $display("[TB] FAIL timeout dut%0d: got no done, expected done within 40 edges", which);
      end
   endtask

   initial begin
      int e, b, dcount;
      logic [63:0] orig, enc;

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset.busy", {60'b0, busy_v}, 64'h0);
      checkOutput("reset.done", {60'b0, done_v}, 64'h0);
      checkOutput("reset.result_a", res_a, 64'h0);
      checkOutput("reset.result_d", res_d, 64'h0);
      rst = 1'b0;
      check_en = 1'b1;

      checkOutput("model.encrypt", desModel(PLAIN, KSCHED, 1'b0, 16), CIPHER);
      checkOutput("model.decrypt", desModel(CIPHER, KSCHED, 1'b1, 16), PLAIN);

      $display("[TB] full DES, one round per clock");
      applyStimulus(0, PLAIN, KSCHED, 1'b0);
      waitDone(0, e, b);
      checkOutput("A.enc.latency", 64'(e), 64'd16);
      checkOutput("A.enc.busy_cycles", 64'(b), 64'd16);
      checkOutput("A.enc.result", res_a, CIPHER);
      applyStimulus(0, CIPHER, KSCHED, 1'b1);
      waitDone(0, e, b);
      checkOutput("A.dec.result", res_a, PLAIN);

      $display("[TB] four rounds per clock");
      applyStimulus(1, CIPHER, KSCHED, 1'b1);
      waitDone(1, e, b);
      checkOutput("B.dec.latency", 64'(e), 64'd4);
      checkOutput("B.dec.result", res_b, PLAIN);
      applyStimulus(1, PLAIN, KSCHED, 1'b0);
      waitDone(1, e, b);
      checkOutput("B.enc.result", res_b, CIPHER);

      $display("[TB] fully unrolled");
      applyStimulus(2, PLAIN, KSCHED, 1'b0);
      waitDone(2, e, b);
      checkOutput("C.latency", 64'(e), 64'd1);
      checkOutput("C.busy_cycles", 64'(b), 64'd1);
      checkOutput("C.result", res_c, CIPHER);

      $display("[TB] start while running is ignored");
      applyStimulus(0, PLAIN, KSCHED, 1'b0);
      repeat (5) @(negedge clk);
      msg = 64'hFEDCBA9876543210;
      keys16 = ~KSCHED;
      dec = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      waitDone(0, e, b);
      checkOutput("A.midstart.result", res_a, CIPHER);
      repeat (3) @(negedge clk);
      checkOutput("A.hold.result", res_a, CIPHER);

      $display("[TB] back-to-back with start held");
      msg = PLAIN;
      keys16 = KSCHED;
      dec = 1'b0;
      start_v[0] = 1'b1;
      @(negedge clk);
      waitDone(0, e, b);
      checkOutput("A.b2b.first_latency", 64'(e), 64'd16);
      checkOutput("A.b2b.first_result", res_a, CIPHER);
      msg = CIPHER;
      dec = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      checkOutput("A.b2b.no_bubble_busy", {63'b0, busy_v[0]}, 64'd1);
      waitDone(0, e, b);
      checkOutput("A.b2b.done_spacing", 64'(e + 1), 64'd17);
      checkOutput("A.b2b.second_result", res_a, PLAIN);

      $display("[TB] reset during a run");
      applyStimulus(0, PLAIN, KSCHED, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("A.rst.busy", {63'b0, busy_v[0]}, 64'd0);
      checkOutput("A.rst.result", res_a, 64'h0);
      rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done_v[0]) dcount++;
      end
      checkOutput("A.rst.no_done", 64'(dcount), 64'd0);
      checkOutput("A.rst.result_after", res_a, 64'h0);
      applyStimulus(0, PLAIN, KSCHED, 1'b0);
      waitDone(0, e, b);
      checkOutput("A.rst.recover_latency", 64'(e), 64'd16);
      checkOutput("A.rst.recover_result", res_a, CIPHER);

      $display("[TB] reduced-round round trip");
      for (int t = 0; t < 2; t++) begin
         orig  = {$urandom(), $urandom()};
         keys4 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
         applyStimulus(3, orig, KSCHED, 1'b0);
         waitDone(3, e, b);
         checkOutput("D.enc.latency", 64'(e), 64'd4);
         enc = res_d;
         checkOutput("D.enc.result", enc, desModel(orig, {keys4, 576'b0}, 1'b0, 4));
         applyStimulus(3, enc, KSCHED, 1'b1);
         waitDone(3, e, b);
         checkOutput("D.roundtrip", res_d, orig);
      end

      repeat (2) @(negedge clk);
      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
